mem_wb_pipe_stage: RTL
======================

// Module: mem_wb_pipe_stage
// PURPOSE
//  MEM->WB pipeline stage with valid/ready handshake, flush and an optional 2-entry skid buffer.
//  Carries the control bundle, ALU result, load data and rd from MEM to write-back.
//  Provides a registered write-back value for forwarding and a saturating stall counter.
//  Sits between the data-memory stage and the register-file write port.
// PARAMETERS
//  D_SIZE    32  width of ALU result and load data
//  RA_SIZE   5   register-address width
//  USE_SKID  1   1 = 2-entry skid buffer; 0 = single register, in_ready = out_ready | ~out_valid
//  CNT_W     16  width of stall counter
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        MEM stage holds a valid instruction
//  in_ready     out  1        stage can accept this cycle
//  in_regwrite  in   1        write register file
//  in_memtoreg  in   1        1 = write load data, 0 = write ALU result
//  in_memread   in   1        instruction is a load
//  in_result    in   D_SIZE   ALU result
//  in_rdata     in   D_SIZE   data-memory read data
//  in_rd        in   RA_SIZE  destination register
//  flush        in   1        kill all held and incoming instructions
//  out_valid    out  1        WB holds a valid instruction
//  out_ready    in   1        WB consumes this cycle
//  wb_regwrite  out  1        in_regwrite & out_valid & (rd != 0)
//  wb_memread   out  1        held memread, gated by out_valid
//  wb_rd        out  RA_SIZE  held rd
//  wb_data      out  D_SIZE   memtoreg ? rdata : result, selected on capture
//  stall_cnt    out  CNT_W    count of cycles with out_valid & ~out_ready
// BEHAVIOUR
//  - Reset: out_valid=0, skid empty, in_ready=1, wb_* = 0, stall_cnt=0.
//  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
//  - Latency: one cycle from an accepted input to out_valid.
//  - wb_data is muxed before the register, so there is no combinational path from in_* to wb_*.
//  - in_ready is registered: in_ready = ~skid_valid. There is no combinational path from out_ready.
//  - State (USE_SKID=1), with main = output register and skid = overflow register:
//      EMPTY --in-->            ONE
//      ONE   --in & out-->      ONE   (main reloads)
//      ONE   --in & ~out-->     TWO   (input goes to skid)
//      ONE   --out & ~in-->     EMPTY
//      TWO   --out-->           ONE   (skid moves to main; in_ready is 0 in TWO)
//  - flush (highest priority): next state EMPTY. The incoming instruction is dropped.
//    Data regs may keep stale values; out_valid forces wb_regwrite and wb_memread to 0.
//  - Flush and reset behave identically in state. Reset mid-transfer drops everything.
//  - rd==0 never asserts wb_regwrite, whatever in_regwrite says.
//  - In TWO, order is preserved: main drains first, then skid.
//  - USE_SKID=0: single entry. in_ready = out_ready | ~out_valid (combinational).
//  - stall_cnt: +1 on each cycle with out_valid & ~out_ready; saturates at all-ones.
//    Cleared only by rst; flush does not clear it.
//  - No X on outputs after reset. Data fields are loaded only on capture.
// STRUCTURE
//  - Shared package: wb_bundle_t struct {regwrite, memread, rd, data}; localparams for the
//    ST_EMPTY/ST_ONE/ST_TWO encoding.
//  - One sub-module: pipe_skid_buf, a generic 2-entry valid/ready buffer parametrised by
//    payload width. This top packs and unpacks the bundle around it and owns the stall counter.
// TESTING
//  1. rst=1 for 2 cycles -> out_valid=0, in_ready=1, wb_rd=0, stall_cnt=0.
//  2. in_valid=1, rd=5, result=0x1234, memtoreg=0, out_ready=1
//     -> next cycle out_valid=1, wb_rd=5, wb_data=0x1234, wb_regwrite=1.
//  3. Load with memtoreg=1, rdata=0xDEADBEEF, rd=0 -> wb_data=0xDEADBEEF, wb_regwrite=0.
//  4. out_ready=0, send A then B -> in_ready drops after B.
//     Release out_ready -> A then B delivered in order; stall_cnt = number of held cycles.
//  5. State TWO plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1,
//     wb_regwrite=0; the incoming instruction is never delivered.
//  6. CNT_W=4, out_ready=0 held for 20 valid cycles -> stall_cnt saturates at 15.
//     Assert rst -> stall_cnt=0.

Source files
------------

// File: rtl/mem_wb_pipe_stage_pkg.sv
// Shared types and constants for the MEM->WB pipeline stage.
package mem_wb_pipe_stage_pkg;

   // Default datapath widths; the write-back bundle is laid out with these.
   localparam int unsigned WB_D_SIZE  = 32;
   localparam int unsigned WB_RA_SIZE = 5;

   // Occupancy encoding of the two-entry buffer.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   // Everything write-back needs from one instruction. regwrite already has
   // the rd==0 suppression folded in, and data is already the selected value.
   typedef struct packed {
      logic                  regwrite;
      logic                  memread;
      logic [WB_RA_SIZE-1:0] rd;
      logic [WB_D_SIZE-1:0]  data;
   } wb_bundle_t;

endpackage

// File: rtl/mem_wb_pipe_stage_skid_buf.sv
// Generic valid/ready buffer with an optional second (skid) entry.
// The main register always drives the output; the skid register only absorbs
// one word when the output stalls in the same cycle a new word is accepted.
module pipe_skid_buf
   import mem_wb_pipe_stage_pkg::*;
#(
   parameter int unsigned W        = 8,
   parameter bit          USE_SKID = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [1:0]   r_state;
   logic [1:0]   w_state_nxt;
   logic [W-1:0] r_main_data;
   logic [W-1:0] r_skid_data;
   logic         w_in_fire;
   logic         w_out_fire;
   logic         w_load_main_in;
   logic         w_load_main_skid;
   logic         w_load_skid;

   assign w_in_fire  = in_valid & in_ready & ~flush;
   assign w_out_fire = out_valid & out_ready;
   assign out_data   = r_main_data;

   // State register: flush and reset both empty the buffer.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Next-state and load strobes from occupancy and the two handshakes.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and no latch is inferred.
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt    = ST_ONE;
                  w_load_main_in = 1'b1;
               end
            end
            ST_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_load_main_in = 1'b1;
               end else if (w_in_fire) begin
                  w_state_nxt = ST_TWO;
                  w_load_skid = 1'b1;
               end else if (w_out_fire) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (w_out_fire) begin
                  w_state_nxt      = ST_ONE;
                  w_load_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs decoded from the registered occupancy.
   always_comb begin
      out_valid = (r_state != ST_EMPTY);
      if (USE_SKID) in_ready = (r_state != ST_TWO);
      else          in_ready = out_ready | (r_state == ST_EMPTY);
   end

   // Payload registers: written only on capture, stale after flush.
   always_ff @(posedge clk) begin
      // NOTE: the payload is reset because write-back outputs must read zero
      // after reset; otherwise these would be plain enable-only registers.
      if (rst) begin
         r_main_data <= '0;
         r_skid_data <= '0;
      end else begin
         if (w_load_main_in)        r_main_data <= in_data;
         else if (w_load_main_skid) r_main_data <= r_skid_data;
         if (w_load_skid)           r_skid_data <= in_data;
      end
   end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage: packs the write-back bundle, buffers it with a
// valid/ready handshake and flush, and counts output stall cycles.
module mem_wb_pipe_stage
   import mem_wb_pipe_stage_pkg::*;
#(
   parameter int unsigned D_SIZE   = WB_D_SIZE,
   parameter int unsigned RA_SIZE  = WB_RA_SIZE,
   parameter bit          USE_SKID = 1'b1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_regwrite,
   input  logic               in_memtoreg,
   input  logic               in_memread,
   input  logic [D_SIZE-1:0]  in_result,
   input  logic [D_SIZE-1:0]  in_rdata,
   input  logic [RA_SIZE-1:0] in_rd,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               wb_regwrite,
   output logic               wb_memread,
   output logic [RA_SIZE-1:0] wb_rd,
   output logic [D_SIZE-1:0]  wb_data,
   output logic [CNT_W-1:0]   stall_cnt
);

   wb_bundle_t       w_in_bundle;
   wb_bundle_t       w_out_bundle;
   logic             w_out_valid;
   logic [CNT_W-1:0] r_stall_cnt;

   // Select write data and suppress writes to x0 before capture, so the
   // outputs come straight from registers.
   always_comb begin
      w_in_bundle.regwrite = in_regwrite & (in_rd != '0);
      w_in_bundle.memread  = in_memread;
      w_in_bundle.rd       = in_rd;
      w_in_bundle.data     = in_memtoreg ? in_rdata : in_result;
   end

   pipe_skid_buf #(
      .W        ($bits(wb_bundle_t)),
      .USE_SKID (USE_SKID)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (w_in_bundle),
      .out_valid (w_out_valid),
      .out_ready (out_ready),
      .out_data  (w_out_bundle)
   );

   // Control outputs are qualified by out_valid; rd and data may be stale.
   always_comb begin
      out_valid   = w_out_valid;
      wb_regwrite = w_out_valid & w_out_bundle.regwrite;
      wb_memread  = w_out_valid & w_out_bundle.memread;
      wb_rd       = w_out_bundle.rd;
      wb_data     = w_out_bundle.data;
   end

   // Saturating count of cycles where WB holds data it did not consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;

endmodule
